// File: rtl/and_gate_pkg.sv
// Shared constants for the AND gate unit: default widths and the default counter ceiling.
package and_gate_pkg;

  localparam int unsigned DefaultWidth = 1;
  localparam int unsigned DefaultCntW  = 16;

  // Value at which a DefaultCntW-wide hit counter stops counting.
  localparam logic [DefaultCntW-1:0] DefaultCntMax = {DefaultCntW{1'b1}};

endpackage

// File: rtl/and_gate_unit_core.sv
// Pure combinational WIDTH-bit bitwise AND; the logic primitive shared by both output paths.
module and_gate_core
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_gate_unit.sv
// AND gate unit: combinational a & b plus a valid-qualified registered copy,
// an all-ones flag and a saturating count of all-ones results.
module and_gate_unit
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  input  logic             clear_count,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] y_d;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic             hit;

  and_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (a),
    .b (b),
    .y (and_res)
  );

  assign y   = and_res;
  assign hit = in_valid && (&and_res);

  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    count_d = count_q;
    if (in_valid) begin
      y_d     = and_res;
      valid_d = 1'b1;
    end
    // Clear has priority over a coincident hit; the counter sticks at its ceiling.
    if (clear_count) begin
      count_d = '0;
    end else if (hit && (count_q != CntMax)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      count_q   <= '0;
    end else begin
      y_q       <= y_d;
      out_valid <= valid_d;
      count_q   <= count_d;
    end
  end

  assign all_ones  = &y_q;
  assign hit_count = count_q;

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed bench for and_gate_unit: 1-bit truth table, 8-bit registered path,
// 2-bit counter saturation/clear, and asynchronous reset mid-stream.
module tb_and_gate_unit;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=1 instance for the truth table.
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0, c1 = 1'b0;
  logic y1, yq1, ov1, ao1;
  logic [15:0] hc1;

  // WIDTH=8, CNT_W=16 instance.
  logic [7:0] a8 = '0, b8 = '0;
  logic v8 = 1'b0, c8 = 1'b0;
  logic [7:0] y8, yq8;
  logic ov8, ao8;
  logic [15:0] hc8;

  // WIDTH=8, CNT_W=2 instance for saturation.
  logic [7:0] as = '0, bs = '0;
  logic vs = 1'b0, cs = 1'b0;
  logic [7:0] ys, yqs;
  logic ovs, aos;
  logic [1:0] hcs;

  and_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk (clk), .rst (rst), .a (a1), .b (b1), .y (y1), .in_valid (v1),
    .clear_count (c1), .y_q (yq1), .out_valid (ov1), .all_ones (ao1), .hit_count (hc1)
  );

  and_gate_unit #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .y (y8), .in_valid (v8),
    .clear_count (c8), .y_q (yq8), .out_valid (ov8), .all_ones (ao8), .hit_count (hc8)
  );

  and_gate_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk (clk), .rst (rst), .a (as), .b (bs), .y (ys), .in_valid (vs),
    .clear_count (cs), .y_q (yqs), .out_valid (ovs), .all_ones (aos), .hit_count (hcs)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_yq", 32'(yq8), 32'h00);
    check("rst_ov", 32'(ov8), 32'h0);
    check("rst_ao", 32'(ao8), 32'h0);
    check("rst_hc", 32'(hc8), 32'h0000);

    // Truth table with no clock activity.
    a1 = 1'b1; b1 = 1'b1; #1 check("tt_11", 32'(y1), 32'h1);
    a1 = 1'b0; b1 = 1'b0; #1 check("tt_00", 32'(y1), 32'h0);
    a1 = 1'b0; b1 = 1'b1; #1 check("tt_01", 32'(y1), 32'h0);
    a1 = 1'b1; b1 = 1'b0; #1 check("tt_10", 32'(y1), 32'h0);

    a8 = 8'h0F; b8 = 8'hFF; #1 check("y_in_rst", 32'(y8), 32'h0F);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Registered path.
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    #1 check("y_comb", 32'(y8), 32'h30);
    tick();
    check("reg_yq", 32'(yq8), 32'h30);
    check("reg_ov", 32'(ov8), 32'h1);
    check("reg_ao", 32'(ao8), 32'h0);
    check("reg_hc", 32'(hc8), 32'h0000);
    v8 = 1'b0; a8 = 8'h55; b8 = 8'hFF;
    tick();
    check("idle_ov", 32'(ov8), 32'h0);
    check("idle_yq", 32'(yq8), 32'h30);

    // All-ones for three valid cycles.
    a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
    tick();
    check("ones_ao1", 32'(ao8), 32'h1);
    check("ones_hc1", 32'(hc8), 32'h0001);
    tick();
    tick();
    check("ones_ao3", 32'(ao8), 32'h1);
    check("ones_yq3", 32'(yq8), 32'hFF);
    check("ones_hc3", 32'(hc8), 32'h0003);

    // Saturation on the 2-bit counter, then clear beating a hit.
    as = 8'hFF; bs = 8'hFF; vs = 1'b1;
    tick();
    tick();
    tick();
    check("sat_hc3", 32'(hcs), 32'h3);
    tick();
    tick();
    check("sat_hc5", 32'(hcs), 32'h3);
    check("sat_ao", 32'(aos), 32'h1);
    cs = 1'b1;
    tick();
    check("clr_hit", 32'(hcs), 32'h0);
    cs = 1'b0; vs = 1'b0;

    // Bring the 8-bit counter to 2 for the reset test (w8 kept hitting meanwhile).
    c8 = 1'b1; v8 = 1'b0;
    tick();
    check("clr8_hc", 32'(hc8), 32'h0000);
    c8 = 1'b0; v8 = 1'b1;
    tick();
    tick();
    check("pre_rst_hc", 32'(hc8), 32'h0002);
    check("pre_rst_yq", 32'(yq8), 32'hFF);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("arst_yq", 32'(yq8), 32'h00);
    check("arst_ov", 32'(ov8), 32'h0);
    check("arst_hc", 32'(hc8), 32'h0000);
    check("arst_ao", 32'(ao8), 32'h0);
    a8 = 8'h0F; b8 = 8'hFF;
    #1 check("arst_y", 32'(y8), 32'h0F);

    // Reset must keep holding the registers across an edge.
    tick();
    check("hold_rst_ov", 32'(ov8), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
